// File: rtl/mem_refill_responder.sv
// Memory-side responder for the data cache. It performs write-through stores into a word RAM and
// answers a read miss with a 4-beat, critical-word-first line refill after LAT cycles.
module mem_refill_responder #(
    parameter int LAT        = 3,
    parameter int DEPTH      = 1024,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        trans,
    input  logic        MEMW,
    input  logic [11:0] MEM_ADDR,
    input  logic [31:0] MEM_DI,
    output logic [31:0] MEM_DOUT,
    output logic        BA_trans,
    output logic        BA_MEMW,
    output logic [11:0] BA_MEM_ADDR,
    output logic [31:0] BA_MEM_DI,
    output logic        busy
);

    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, BURST, HOLD} state_t;

    state_t        state_q, state_d;
    logic [7:0]    line_q, line_d;
    logic [1:0]    off_q, off_d;
    logic [1:0]    beat_q, beat_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic [31:0]   dout_q, dout_d;
    logic          btrans_q, btrans_d;
    logic          bmemw_q, bmemw_d;
    logic [11:0]   baddr_q, baddr_d;
    logic [31:0]   bdi_q, bdi_d;
    logic          busy_q, busy_d;

    logic [31:0] ram [DEPTH];
    logic        store;
    logic [1:0]  word_off;
    logic [9:0]  beat_word;
    logic        unused_ok;

    assign store     = !MEMW;
    assign word_off  = off_q + beat_q;
    assign beat_word = {line_q, word_off};
    assign unused_ok = &{1'b0, MEM_ADDR[1:0]};

    always_comb begin
        state_d  = state_q;
        line_d   = line_q;
        off_d    = off_q;
        beat_d   = beat_q;
        wcnt_d   = wcnt_q;
        dout_d   = dout_q;
        btrans_d = 1'b0;
        bmemw_d  = 1'b0;
        baddr_d  = baddr_q;
        bdi_d    = store ? MEM_DI : bdi_q;
        busy_d   = busy_q;
        case (state_q)
            IDLE: begin
                if (trans && MEMW) begin
                    line_d  = MEM_ADDR[11:4];
                    off_d   = MEM_ADDR[3:2];
                    wcnt_d  = CW'(LAT - 1);
                    beat_d  = '0;
                    busy_d  = 1'b1;
                    state_d = (LAT == 1) ? BURST : WAIT;
                end
            end
            WAIT: begin
                // Counter reaching zero on this edge means the next edge emits beat 0.
                wcnt_d = wcnt_q - CW'(1);
                if (wcnt_q == CW'(1)) state_d = BURST;
            end
            BURST: begin
                // RAM is read before this edge's store lands, so a colliding store returns old data.
                btrans_d = 1'b1;
                bmemw_d  = 1'b1;
                baddr_d  = {beat_word, 2'b00};
                dout_d   = ram[beat_word];
                beat_d   = beat_q + 2'd1;
                if (beat_q == 2'(LINE_WORDS - 1)) state_d = HOLD;
            end
            HOLD: begin
                if (!trans) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q  <= IDLE;
            line_q   <= '0;
            off_q    <= '0;
            beat_q   <= '0;
            wcnt_q   <= '0;
            dout_q   <= '0;
            btrans_q <= 1'b0;
            bmemw_q  <= 1'b0;
            baddr_q  <= '0;
            bdi_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            line_q   <= line_d;
            off_q    <= off_d;
            beat_q   <= beat_d;
            wcnt_q   <= wcnt_d;
            dout_q   <= dout_d;
            btrans_q <= btrans_d;
            bmemw_q  <= bmemw_d;
            baddr_q  <= baddr_d;
            bdi_q    <= bdi_d;
            busy_q   <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn && store) ram[MEM_ADDR[11:2]] <= MEM_DI;
    end

    assign MEM_DOUT    = dout_q;
    assign BA_trans    = btrans_q;
    assign BA_MEMW     = bmemw_q;
    assign BA_MEM_ADDR = baddr_q;
    assign BA_MEM_DI   = bdi_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_mem_refill_responder.sv
// Bench for mem_refill_responder: a vector table, hand-written corner sequences and random traffic.
// Every edge is checked against a timeline model of the refill protocol.
module tb_mem_refill_responder;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rstn;
    logic        trans;
    logic        MEMW;
    logic [11:0] MEM_ADDR;
    logic [31:0] MEM_DI;
    logic [31:0] MEM_DOUT;
    logic        BA_trans;
    logic        BA_MEMW;
    logic [11:0] BA_MEM_ADDR;
    logic [31:0] BA_MEM_DI;
    logic        busy;

    mem_refill_responder #(.LAT(LAT), .DEPTH(1024), .LINE_WORDS(4)) dut (
        .clk(clk), .rstn(rstn), .trans(trans), .MEMW(MEMW), .MEM_ADDR(MEM_ADDR),
        .MEM_DI(MEM_DI), .MEM_DOUT(MEM_DOUT), .BA_trans(BA_trans), .BA_MEMW(BA_MEMW),
        .BA_MEM_ADDR(BA_MEM_ADDR), .BA_MEM_DI(BA_MEM_DI), .busy(busy)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    // Reference model: a refill is described by its acceptance cycle; beat k is due LAT+k edges later.
    logic [31:0] mem   [1024];
    bit          known [1024];
    int          cyc = 0;
    int          m_start = 0;
    bit          m_busy = 0;
    bit          m_bt = 0;
    logic [7:0]  m_line = '0;
    logic [1:0]  m_off = '0;
    logic [11:0] m_addr = '0;
    logic [31:0] m_dout = '0;
    bit          m_dout_known = 1;
    logic [31:0] m_bdi = '0;

    typedef struct {
        logic        tr;
        logic        mw;
        logic [11:0] a;
        logic [31:0] di;
        logic        e_bt;
        logic        e_busy;
        logic [11:0] e_addr;
        logic [31:0] e_dout;
        logic [31:0] e_bdi;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_busy = 0; m_bt = 0; m_addr = '0; m_dout = '0; m_dout_known = 1; m_bdi = '0;
    endtask

    task automatic model_edge(input logic tr, input logic mw, input logic [11:0] a,
                              input logic [31:0] di);
        int d;
        logic [1:0] o;
        logic [9:0] w;
        m_bt = 0;
        if (m_busy) begin
            d = cyc - m_start;
            if (d >= LAT && d < LAT + 4) begin
                o = m_off + 2'(d - LAT);
                w = {m_line, o};
                m_bt = 1;
                m_addr = {w, 2'b00};
                m_dout = mem[w];
                m_dout_known = known[w];
            end
            if (d >= LAT + 4 && !tr) m_busy = 0;
        end else if (tr && mw) begin
            m_busy = 1; m_start = cyc; m_line = a[11:4]; m_off = a[3:2];
        end
        if (!mw) begin
            mem[a[11:2]] = di; known[a[11:2]] = 1; m_bdi = di;
        end
        cyc++;
    endtask

    task automatic check_model();
        chk("BA_trans", {31'b0, BA_trans}, {31'b0, m_bt});
        chk("BA_MEMW", {31'b0, BA_MEMW}, {31'b0, m_bt});
        chk("busy", {31'b0, busy}, {31'b0, m_busy});
        chk("BA_MEM_DI", BA_MEM_DI, m_bdi);
        chk("BA_MEM_ADDR", {20'b0, BA_MEM_ADDR}, {20'b0, m_addr});
        if (m_dout_known) chk("MEM_DOUT", MEM_DOUT, m_dout);
    endtask

    // Inputs change at the falling edge; outputs are sampled 1 time unit after the rising edge.
    task automatic step(input logic tr, input logic mw, input logic [11:0] a, input logic [31:0] di);
        trans = tr; MEMW = mw; MEM_ADDR = a; MEM_DI = di;
        @(posedge clk);
        model_edge(tr, mw, a, di);
        #1 check_model();
        @(negedge clk);
    endtask

    int beats;

    initial begin
        for (int i = 0; i < 1024; i++) begin mem[i] = '0; known[i] = 0; end
        rstn = 1'b1; trans = 1'b0; MEMW = 1'b1; MEM_ADDR = '0; MEM_DI = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst MEM_DOUT", MEM_DOUT, 32'h0);
        chk("rst BA_trans", {31'b0, BA_trans}, 32'h0);
        chk("rst BA_MEMW", {31'b0, BA_MEMW}, 32'h0);
        chk("rst BA_MEM_ADDR", {20'b0, BA_MEM_ADDR}, 32'h0);
        chk("rst BA_MEM_DI", BA_MEM_DI, 32'h0);
        chk("rst busy", {31'b0, busy}, 32'h0);
        @(negedge clk);
        rstn = 1'b0;

        // Stores, then a critical-word-first refill of 0x108, held one cycle past the burst.
        tbl[0]  = '{1'b0, 1'b0, 12'h100, 32'hA0, 1'b0, 1'b0, 12'h000, 32'h0,  32'hA0};
        tbl[1]  = '{1'b0, 1'b0, 12'h104, 32'hA1, 1'b0, 1'b0, 12'h000, 32'h0,  32'hA1};
        tbl[2]  = '{1'b0, 1'b0, 12'h108, 32'hA2, 1'b0, 1'b0, 12'h000, 32'h0,  32'hA2};
        tbl[3]  = '{1'b0, 1'b0, 12'h10C, 32'hA3, 1'b0, 1'b0, 12'h000, 32'h0,  32'hA3};
        tbl[4]  = '{1'b1, 1'b1, 12'h108, 32'h0,  1'b0, 1'b1, 12'h000, 32'h0,  32'hA3};
        tbl[5]  = '{1'b1, 1'b1, 12'h108, 32'h0,  1'b0, 1'b1, 12'h000, 32'h0,  32'hA3};
        tbl[6]  = '{1'b1, 1'b1, 12'h108, 32'h0,  1'b0, 1'b1, 12'h000, 32'h0,  32'hA3};
        tbl[7]  = '{1'b1, 1'b1, 12'h108, 32'h0,  1'b1, 1'b1, 12'h108, 32'hA2, 32'hA3};
        tbl[8]  = '{1'b1, 1'b1, 12'h108, 32'h0,  1'b1, 1'b1, 12'h10C, 32'hA3, 32'hA3};
        tbl[9]  = '{1'b1, 1'b1, 12'h108, 32'h0,  1'b1, 1'b1, 12'h100, 32'hA0, 32'hA3};
        tbl[10] = '{1'b1, 1'b1, 12'h108, 32'h0,  1'b1, 1'b1, 12'h104, 32'hA1, 32'hA3};
        tbl[11] = '{1'b1, 1'b1, 12'h108, 32'h0,  1'b0, 1'b1, 12'h000, 32'h0,  32'hA3};
        tbl[12] = '{1'b0, 1'b1, 12'h108, 32'h0,  1'b0, 1'b0, 12'h000, 32'h0,  32'hA3};
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].tr, tbl[i].mw, tbl[i].a, tbl[i].di);
            chk($sformatf("tbl%0d BA_trans", i), {31'b0, BA_trans}, {31'b0, tbl[i].e_bt});
            chk($sformatf("tbl%0d busy", i), {31'b0, busy}, {31'b0, tbl[i].e_busy});
            chk($sformatf("tbl%0d BA_MEM_DI", i), BA_MEM_DI, tbl[i].e_bdi);
            if (tbl[i].e_bt) begin
                chk($sformatf("tbl%0d BA_MEM_ADDR", i), {20'b0, BA_MEM_ADDR}, {20'b0, tbl[i].e_addr});
                chk($sformatf("tbl%0d MEM_DOUT", i), MEM_DOUT, tbl[i].e_dout);
            end
        end

        // Store echo, then a refill of that word held for 10 cycles beyond the burst.
        step(1'b0, 1'b0, 12'h3F0, 32'h1234);
        chk("echo BA_MEM_DI", BA_MEM_DI, 32'h1234);
        beats = 0;
        for (int i = 0; i < LAT + 4 + 10; i++) begin
            step(1'b1, 1'b1, 12'h3F0, 32'h0);
            if (BA_trans) beats++;
            if (i == LAT) begin
                chk("3F0 beat0 addr", {20'b0, BA_MEM_ADDR}, 32'h3F0);
                chk("3F0 beat0 data", MEM_DOUT, 32'h1234);
            end
        end
        chk("held beat count", beats, 4);
        chk("held busy", {31'b0, busy}, 32'h1);
        step(1'b0, 1'b1, 12'h3F0, 32'h0);
        chk("drop busy", {31'b0, busy}, 32'h0);

        // Stores colliding with a burst of line 0x100 starting at offset 0.
        for (int i = 0; i < LAT; i++) step(1'b1, 1'b1, 12'h100, 32'h0);
        step(1'b1, 1'b0, 12'h100, 32'h5555);
        chk("same-cycle old data", MEM_DOUT, 32'hA0);
        step(1'b1, 1'b0, 12'h10C, 32'hBEEF);
        chk("beat1 data", MEM_DOUT, 32'hA1);
        step(1'b1, 1'b1, 12'h100, 32'h0);
        step(1'b1, 1'b1, 12'h100, 32'h0);
        chk("beat3 new data", MEM_DOUT, 32'hBEEF);
        chk("beat3 addr", {20'b0, BA_MEM_ADDR}, 32'h10C);
        step(1'b0, 1'b1, 12'h100, 32'h0);
        step(1'b0, 1'b1, 12'h100, 32'h0);

        // Reset asserted right after the second beat of a refill.
        for (int i = 0; i < LAT + 2; i++) step(1'b1, 1'b1, 12'h104, 32'h0);
        chk("pre-reset BA_trans", {31'b0, BA_trans}, 32'h1);
        trans = 1'b0; MEMW = 1'b1;
        rstn = 1'b1;
        #1;
        chk("async rst BA_trans", {31'b0, BA_trans}, 32'h0);
        chk("async rst busy", {31'b0, busy}, 32'h0);
        chk("async rst BA_MEM_DI", BA_MEM_DI, 32'h0);
        model_reset();
        @(posedge clk);
        #1 chk("rst hold BA_trans", {31'b0, BA_trans}, 32'h0);
        @(negedge clk);
        rstn = 1'b0;
        for (int i = 0; i < LAT + 1; i++) step(1'b1, 1'b1, 12'h100, 32'h0);
        chk("post-reset beat0", MEM_DOUT, 32'h5555);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 12'h100, 32'h0);
        chk("post-reset beat3", MEM_DOUT, 32'hBEEF);
        step(1'b0, 1'b1, 12'h100, 32'h0);
        step(1'b0, 1'b1, 12'h100, 32'h0);

        // trans with MEMW=0 in IDLE is a plain store.
        step(1'b1, 1'b0, 12'h040, 32'hCAFEF00D);
        chk("trans+write busy", {31'b0, busy}, 32'h0);
        chk("trans+write echo", BA_MEM_DI, 32'hCAFEF00D);
        beats = 0;
        for (int i = 0; i < LAT + 5; i++) begin
            step(1'b0, 1'b1, 12'h040, 32'h0);
            if (BA_trans || busy) beats++;
        end
        chk("trans+write no refill", beats, 0);

        // Random traffic over lines 0x20..0x2F, after initialising them.
        for (int w = 0; w < 64; w++) step(1'b0, 1'b0, 12'(12'h200 + w * 4), $urandom);
        for (int i = 0; i < 600; i++)
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
                 12'(12'h200 + $urandom_range(0, 255)), $urandom);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_refill_responder.md
# mem_refill_responder

Memory-side responder for the data cache's miss/write-through interface. It owns a word-addressed backing RAM, performs single-cycle write-through stores, and answers a read-miss request with a 4-beat critical-word-first line refill after a fixed access latency. It sits between the data cache's memory port (`trans`/`MEMW`/`MEM_ADDR`/`MEM_DI`) and its refill port (`BA_*`, `MEM_DOUT`).

## Interface
- `LAT`, 3: cycles from request acceptance to first refill beat (≥1)
- `DEPTH`, 1024: RAM words (indexed by `MEM_ADDR[11:2]`)
- `LINE_WORDS`, 4: beats per refill (fixed; line = `ADDR[11:4]`, word = `ADDR[3:2]`)
- `clk` in 1: clock
- `rstn` in 1: reset; asynchronous, active-high (reset rstn, asynchronous, active-high; clock clk)
- `trans` in 1: read-miss request, level, held by cache while stalled
- `MEMW` in 1: 1 = read, 0 = write
- `MEM_ADDR` in 12: byte address; bits [1:0] ignored
- `MEM_DI` in 32: store data
- `MEM_DOUT` out 32: refill beat data
- `BA_trans` out 1: refill beat valid
- `BA_MEMW` out 1: 1 during refill beats, else 0
- `BA_MEM_ADDR` out 12: address of current beat, bits [1:0] = 00
- `BA_MEM_DI` out 32: echo of last written word, valid the cycle after a write
- `busy` out 1: high from acceptance until back in IDLE

## Operation
- States: IDLE, WAIT, BURST, HOLD.
- IDLE: `MEMW`=0 → store `MEM_DI` to `ram[MEM_ADDR[11:2]]` at edge; `BA_MEM_DI` updated next cycle. Else `trans`=1 & `MEMW`=1 → latch line `MEM_ADDR[11:4]`, start offset `MEM_ADDR[3:2]`, load wait counter with `LAT-1`, go WAIT (or directly BURST if `LAT`=1).
- WAIT: decrement counter; at 0 go BURST, beat counter k=0.
- BURST: each cycle drive beat k: `BA_MEM_ADDR` = {line, (off+k) mod 4, 2'b00}, `MEM_DOUT` = ram at that word, `BA_trans`=1, `BA_MEMW`=1. After k=3 go HOLD.
- HOLD: wait for `trans`=0, then IDLE. A request still held after the burst is never re-served.
- Stores are accepted in every state (write-through never blocks). RAM is read-before-write: a beat and a store to the same word in the same cycle returns old data; stores to not-yet-sent words of the line return new data.
- `MEM_ADDR`/`trans` changes during WAIT/BURST are ignored (line/offset latched).
- Offset arithmetic 2-bit, wraps 3→0. Line index is never incremented.

## Timing
- All outputs registered. Reset values: `MEM_DOUT`=0, `BA_trans`=0, `BA_MEMW`=0, `BA_MEM_ADDR`=0, `BA_MEM_DI`=0, `busy`=0, state IDLE, counters 0. RAM contents not reset.
- Acceptance at edge E0 (IDLE, `trans`=1, `MEMW`=1): `busy`=1 after E0; `BA_trans`=1 after edges E0+LAT … E0+LAT+3 (4 consecutive cycles), 0 after E0+LAT+4.
- `busy` falls after the first edge in HOLD sampling `trans`=0; earliest IDLE re-accept is the following edge.
- Store at edge Ew: `BA_MEM_DI`=`MEM_DI` after Ew; holds until next store.
- Simultaneous `trans`=1 and `MEMW`=0 in IDLE: store performed, no refill started.
- `rstn` asserted mid-WAIT/BURST: outputs to reset values immediately, burst aborted, no further beats; RAM retains data.

## Test plan
- Store 0xA0..0xA3 to 0x100,0x104,0x108,0x10C; read-miss at 0x108, LAT=3 → beats after E0+3..E0+6: (0x108,0xA2),(0x10C,0xA3),(0x100,0xA0),(0x104,0xA1); `busy` 1 from E0 until `trans` drops.
- Store 0x1234 to 0x3F0 → `BA_MEM_DI`=0x1234 next cycle; refill of 0x3F0 returns 0x1234 on beat 0.
- Hold `trans`=1 for 10 cycles after burst → exactly 4 beats total, `busy` stays 1; drop `trans` → `busy`=0 next edge.
- During burst of 0x100 (offset 0), store 0xBEEF to 0x10C at beat 1 → beat 3 returns 0xBEEF; same-cycle store to beat-0 word returns old value.
- Assert `rstn` at second beat → `BA_trans`=0, `busy`=0 immediately; after release, new refill succeeds with RAM intact.
- `trans`=1 with `MEMW`=0 in IDLE → write only, `BA_trans` never asserts, `busy`=0.
